// File: rtl/mem_resp_if.sv
// Core-to-memory request bus: the core drives req/we/addr/wdata and holds req until ack.
// The responder returns rdata with a one-cycle ack and flags busy while a request is in flight.
interface mem_resp_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [31:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;
  logic             busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mem_resp.sv
// Word-addressed memory responder: one request at a time, ack LATENCY cycles after req is first presented.
// No backpressure path; inputs are sampled only in IDLE and ignored while busy.
module mem_resp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input logic      clk,
  input logic      reset,
  mem_resp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rdata_q;

  logic [WIDTH-1:0]      mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  do_op;
  logic                  op_we;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [WIDTH-1:0]      op_wdata;
  logic                  unused_addr;

  assign idx_in      = bus.addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

  // The memory access happens on the edge entering RESP. With LATENCY=1 that edge is
  // the acceptance edge itself, so the request registers are not loaded yet and the
  // live bus values are used instead. Gating with reset keeps a held reset from committing.
  always_comb begin
    do_op    = 1'b0;
    op_we    = we_q;
    op_idx   = idx_q;
    op_wdata = wdata_q;
    if (state == IDLE && bus.req && LATENCY == 1) begin
      do_op    = reset;
      op_we    = bus.we;
      op_idx   = idx_in;
      op_wdata = bus.wdata;
    end else if (state == WAIT && cnt == 4'd1) begin
      do_op    = reset;
    end
  end

  always_ff @(posedge clk) begin
    if (do_op && op_we) begin
      mem[op_idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (do_op && !op_we) begin
        rdata_q <= mem[op_idx];
      end
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            idx_q   <= idx_in;
            wdata_q <= bus.wdata;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = (state == RESP);
  assign bus.busy  = (state != IDLE);

endmodule
